ifetch16: RTL and testbench



---
 rtl/ifetch16.sv | 102 ++++++++++
 tb/tb_ifetch16.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ifetch16.sv
// Instruction supply for the 8-bit core: writable program store plus PC,
// one word per core fetch request, with jump redirect and halt-word detection.
module ifetch16 #(
  parameter int unsigned     AW        = 4,
  parameter logic [AW-1:0]   RST_PC    = '0,
  parameter logic [15:0]     HALT_WORD = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          run,
  input  logic          req,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_addr,
  output logic [15:0]   inst,
  output logic          vld,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   inst_q, inst_d;
  logic          vld_q, vld_d;

  logic [15:0]   mem_q [2**AW];
  logic [AW-1:0] fetch_addr;
  logic [15:0]   fetch_word;

  // Program store is deliberately left out of reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == S_IDLE) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign fetch_addr = jmp ? jmp_addr : pc_q;
  assign fetch_word = mem_q[fetch_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RST_PC;
      inst_q  <= 16'h0000;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    vld_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          pc_d    = RST_PC;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (req) begin
          // The halt word is never delivered; PC parks on it.
          if (fetch_word == HALT_WORD) begin
            pc_d    = fetch_addr;
            state_d = S_HALT;
          end else begin
            inst_d = fetch_word;
            vld_d  = 1'b1;
            pc_d   = fetch_addr + 1'b1;
          end
        end else if (jmp) begin
          pc_d = jmp_addr;
        end
      end
      S_HALT: begin
        if (run) begin
          pc_d    = RST_PC;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign inst   = inst_q;
  assign vld    = vld_q;
  assign pc     = pc_q;
  assign halted = (state_q == S_HALT);
  assign busy   = (state_q == S_RUN);

endmodule

// File: tb/tb_ifetch16.sv
// Directed bench for ifetch16: a default instance (RST_PC=0) and a second
// instance with RST_PC=15 for the wrap-around case.
module tb_ifetch16;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rst2 = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic        run = 1'b0, req = 1'b0, jmp = 1'b0;
  logic [3:0]  jmp_addr = '0;

  logic [15:0] inst, inst2;
  logic        vld, vld2, halted, halted2, busy, busy2;
  logic [3:0]  pc, pc2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ifetch16 #(.AW(4), .RST_PC(4'd0)) u_dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .run(run), .req(req), .jmp(jmp), .jmp_addr(jmp_addr),
    .inst(inst), .vld(vld), .pc(pc), .halted(halted), .busy(busy)
  );

  ifetch16 #(.AW(4), .RST_PC(4'd15)) u_wrap (
    .clk(clk), .rst(rst2), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .run(run), .req(req), .jmp(jmp), .jmp_addr(jmp_addr),
    .inst(inst2), .vld(vld2), .pc(pc2), .halted(halted2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  // Checks the common fetch outputs of the default instance in one line.
  task automatic chk_out(input string tag, input logic [15:0] e_inst, input logic e_vld,
                         input logic [3:0] e_pc);
    chk({tag, ".inst"}, inst, e_inst);
    chk({tag, ".vld"}, 16'(vld), 16'(e_vld));
    chk({tag, ".pc"}, 16'(pc), 16'(e_pc));
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 16'h0000, 1'b0, 4'd0);
    chk("reset.halted", 16'(halted), 16'd0);
    chk("reset.busy", 16'(busy), 16'd0);
    chk("reset2.pc", 16'(pc2), 16'd15);

    // Load program; req/jmp in IDLE must be ignored.
    req = 1'b1; jmp = 1'b1; jmp_addr = 4'd7;
    wr(4'd0, 16'h1C12);
    wr(4'd1, 16'h1C23);
    wr(4'd2, 16'hFFFF);
    wr(4'd5, 16'h5555);
    req = 1'b0; jmp = 1'b0;
    chk_out("idle_ign", 16'h0000, 1'b0, 4'd0);

    // Sequential fetch to halt.
    run = 1'b1; tick(); run = 1'b0;
    chk("run.busy", 16'(busy), 16'd1);
    req = 1'b1;
    tick(); chk_out("seq0", 16'h1C12, 1'b1, 4'd1);
    tick(); chk_out("seq1", 16'h1C23, 1'b1, 4'd2);
    tick(); chk_out("halt", 16'h1C23, 1'b0, 4'd2);
    chk("halt.halted", 16'(halted), 16'd1);
    chk("halt.busy", 16'(busy), 16'd0);
    jmp = 1'b1; jmp_addr = 4'd9;
    tick(); chk_out("halt_hold", 16'h1C23, 1'b0, 4'd2);
    req = 1'b0; jmp = 1'b0;

    // Jump with req from pc=1.
    run = 1'b1; tick(); run = 1'b0;
    chk("rerun.pc", 16'(pc), 16'd0);
    req = 1'b1; tick(); chk_out("pre_jmp", 16'h1C12, 1'b1, 4'd1);
    jmp = 1'b1; jmp_addr = 4'd5;
    tick(); chk_out("jmp_req", 16'h5555, 1'b1, 4'd6);
    req = 1'b0; jmp = 1'b0;

    // Writes in RUN are dropped; jmp without req only moves pc.
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'h0000;
    tick(); prog_we = 1'b0;
    chk_out("run_we", 16'h5555, 1'b0, 4'd6);
    jmp = 1'b1; jmp_addr = 4'd2;
    tick(); jmp = 1'b0;
    chk_out("jmp_only", 16'h5555, 1'b0, 4'd2);
    req = 1'b1; tick(); req = 1'b0;
    chk("halt2.halted", 16'(halted), 16'd1);

    // Alternating req after rerun; mem[0] must still hold the original word.
    run = 1'b1; tick(); run = 1'b0;
    req = 1'b1; tick(); chk_out("alt0", 16'h1C12, 1'b1, 4'd1);
    req = 1'b0; tick(); chk_out("alt_gap0", 16'h1C12, 1'b0, 4'd1);
    run = 1'b1; tick(); run = 1'b0;
    chk_out("run_in_run", 16'h1C12, 1'b0, 4'd1);
    req = 1'b1; tick(); chk_out("alt1", 16'h1C23, 1'b1, 4'd2);
    req = 1'b0; tick(); chk_out("alt_gap1", 16'h1C23, 1'b0, 4'd2);

    // Reset while a fetch is in flight.
    req = 1'b1; jmp = 1'b1; jmp_addr = 4'd0;
    rst = 1'b1; tick(); rst = 1'b0; req = 1'b0; jmp = 1'b0;
    chk_out("rst_mid", 16'h0000, 1'b0, 4'd0);
    chk("rst_mid.busy", 16'(busy), 16'd0);
    run = 1'b1; tick(); run = 1'b0;
    req = 1'b1; tick(); req = 1'b0;
    chk_out("post_rst", 16'h1C12, 1'b1, 4'd1);

    // Wrap-around on the RST_PC=15 instance.
    rst = 1'b1; rst2 = 1'b0;
    wr(4'd15, 16'hABCD);
    wr(4'd0, 16'h1234);
    run = 1'b1; tick(); run = 1'b0;
    chk("wrap.pc_start", 16'(pc2), 16'd15);
    req = 1'b1;
    tick();
    chk("wrap0.inst", inst2, 16'hABCD);
    chk("wrap0.pc", 16'(pc2), 16'd0);
    tick();
    chk("wrap1.inst", inst2, 16'h1234);
    chk("wrap1.vld", 16'(vld2), 16'd1);
    chk("wrap1.pc", 16'(pc2), 16'd1);
    req = 1'b0;
    tick();
    chk("wrap_gap.vld", 16'(vld2), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
